ps2_host_rx: RTL and testbench
==============================

Name: ps2_host_rx

Overview:
- Core-side PS/2 host receiver. Deserialises the PS/2 device-to-host frames that user_io emits on ps2_kbd_clk/ps2_kbd_data or ps2_mouse_clk/ps2_mouse_data.
- Each frame is start, 8 data bits LSB first, odd parity, stop. Good bytes are buffered in a small show-ahead FIFO for the core's keyboard or mouse controller.
- One instance per channel (keyboard, mouse). Runs in the core system clock domain.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised samples required before the filtered ps2 clk/data level changes.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge mid-frame before the frame is aborted.
- FIFO_BITS, 3: log2 of FIFO depth (default 8 entries).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_clk_in  in  1  PS/2 clock, asynchronous to clk
- ps2_data_in  in  1  PS/2 data, asynchronous to clk
- rx_data  out  8  FIFO head byte, valid when rx_valid=1
- rx_valid  out  1  FIFO non-empty
- rx_rd  in  1  pop head; ignored when rx_valid=0
- parity_err  out  1  one-cycle pulse: frame dropped, bad parity
- frame_err  out  1  one-cycle pulse: frame dropped, stop bit=0 or timeout
- overflow  out  1  one-cycle pulse: good byte dropped, FIFO full
- ps2_clk_oe  out  1  drive PS/2 clock low (inhibit); only with PS2_RX_INHIBIT_EN

Behaviour:
- Input conditioning:
  - 2-flop synchroniser on each of ps2_clk_in and ps2_data_in.
  - Per-signal filter: the filtered level takes the new value after FILTER_LEN consecutive equal samples. Filtered level resets to 1.
  - fall = filtered clk 1->0. All sampling uses the filtered data level in the cycle fall is detected.
- FSM (reset -> IDLE). Shift register sr[7:0], bit counter cnt[2:0], parity accumulator par.
  - IDLE: on fall with data=0 -> DATA, cnt=0, par=1. On fall with data=1 -> stay IDLE (spurious edge, no error).
  - DATA: on fall, sr={data,sr[7:1]}, par^=data. cnt=7 -> PARITY, else cnt++.
  - PARITY: on fall, par^=data -> STOP.
  - STOP: on fall:
    - data=0 -> frame_err.
    - else par!=0 -> parity_err. Odd parity requires the XOR of 8 data bits plus the parity bit to be 1, i.e. final par==0.
    - else push sr.
    - Always -> IDLE.
- Timeout:
  - Counter clears on every fall and while in IDLE.
  - In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES -> frame_err pulse, -> IDLE. The partial byte is discarded.
- Latency: the push occurs in the cycle after the stop-bit fall. rx_valid and rx_data are visible the following cycle.
- FIFO:
  - Depth 2**FIFO_BITS; wptr/rptr of FIFO_BITS+1 bits for full/empty.
  - rx_data = mem[rptr]. rx_valid = (wptr!=rptr).
  - Push when full: byte dropped, overflow pulse, pointers unchanged.
  - Simultaneous push and rx_rd on a full FIFO: both take effect, no overflow.
  - Simultaneous push and rx_rd on an empty FIFO: the pop is ignored and the push takes effect.
- Error pulses are mutually exclusive per frame. Each is exactly 1 cycle.
- Reset, also mid-frame: FSM IDLE, pointers 0, filters/synchronisers 1, all pulses 0, rx_valid 0, ps2_clk_oe 0.

Optional Feature:
- Macro: PS2_RX_INHIBIT_EN.
- Defined: ps2_clk_oe=1 while the FIFO is full and FSM is IDLE. The device holds off, so no byte is lost between frames. It deasserts the cycle after the FIFO leaves full. It is never asserted mid-frame; a frame already started can still overflow.
- Undefined: ps2_clk_oe is tied 0 and has no inhibit logic.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Frame constants: 8 data bits, START=0, STOP=1.
  - Default FILTER_LEN and TIMEOUT_CYCLES.
- One sub-module, ps2_sync_filter: synchroniser plus debounce filter, instantiated twice (clk, data), parameter FILTER_LEN.
- FIFO stays inline.

Test Plan:
- Frame 0x1C with parity 0, stop 1, ~60 µs bit period -> rx_valid with rx_data=0x1C; no error pulses; rx_rd empties the FIFO.
- Frame 0xF0 with parity 0 (should be 1) -> one parity_err pulse, rx_valid stays 0. Then a correct 0xF0 frame -> rx_data=0xF0.
- Frame 0x5A with stop bit 0 -> frame_err. Separately, stop clocking after 4 data bits for >50000 cycles -> frame_err, FSM IDLE; next good frame 0x12 is received.
- FIFO_BITS=2, no reads, 5 frames 0x01..0x05 -> first four buffered, overflow pulse on 5th; reads return 0x01,0x02,0x03,0x04. With PS2_RX_INHIBIT_EN, ps2_clk_oe=1 after the 4th byte until the first rx_rd.
- 3-cycle glitch low on ps2_clk_in in IDLE, FILTER_LEN=8 -> no fall, no state change. Reset asserted mid-frame after 3 bits, then a good frame 0x29 -> rx_data=0x29 only.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding, frame framing constants
// and default tuning values for the host receiver and its input filter.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int   FRAME_BITS         = 8;
  localparam logic START_BIT          = 1'b0;
  localparam logic STOP_BIT           = 1'b1;
  localparam int   DEF_FILTER_LEN     = 8;
  localparam int   DEF_TIMEOUT_CYCLES = 50000;
  localparam int   DEF_FIFO_BITS      = 3;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a debounce filter: the output level follows
// the input only after FILTER_LEN consecutive samples disagree with it.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      cnt     <= '0;
      level   <= 1'b1;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // Any sample matching the current level restarts the run
      if (sync_p1 != level) begin
        if (cnt == CNT_W'(FILTER_LEN - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 device-to-host frame receiver with a show-ahead byte FIFO.
// Optional clock inhibit while the FIFO is full: define PS2_RX_INHIBIT_EN.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FIFO_BITS      = DEF_FIFO_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rd,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       ps2_clk_oe
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int PW    = FIFO_BITS + 1;

  logic clk_f;
  logic data_f;
  logic clk_f_p1;
  logic fall;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .din   (ps2_clk_in),
    .level (clk_f)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .reset (reset),
    .din   (ps2_data_in),
    .level (data_f)
  );

  always_ff @(posedge clk) begin
    if (reset) clk_f_p1 <= 1'b1;
    else       clk_f_p1 <= clk_f;
  end

  assign fall = clk_f_p1 & ~clk_f;

  // ---- frame FSM ----
  ps2_state_t             state;
  logic [FRAME_BITS-1:0]  sr;
  logic [2:0]             cnt;
  logic                   par;
  logic [TO_W-1:0]        to_cnt;
  logic                   push_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      push_req   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push_req   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TO_W'(1);

      case (state)
        IDLE: begin
          if (fall && data_f == START_BIT) begin
            state <= DATA;
            cnt   <= '0;
            par   <= 1'b1;
          end
        end
        DATA: begin
          if (fall) begin
            par <= par ^ data_f;
            if (cnt == 3'(FRAME_BITS - 1)) state <= PARITY;
            else                           cnt   <= cnt + 3'd1;
          end
        end
        PARITY: begin
          if (fall) begin
            par   <= par ^ data_f;
            state <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            if (data_f != STOP_BIT) frame_err  <= 1'b1;
            else if (par)           parity_err <= 1'b1;
            else                    push_req   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A stalled device abandons the partial byte
      if (state != IDLE && !fall && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && fall) sr <= {data_f, sr[FRAME_BITS-1:1]};
  end

  // ---- show-ahead FIFO ----
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                   (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);
  assign do_pop  = rx_rd & ~empty;
  assign do_push = push_req & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req & full & ~do_pop;
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[FIFO_BITS-1:0]] <= sr;
  end

  assign rx_data  = mem[rptr[FIFO_BITS-1:0]];
  assign rx_valid = ~empty;

`ifdef PS2_RX_INHIBIT_EN
  // Only hold the line between frames, and let go as soon as a pop is taken
  always_ff @(posedge clk) begin
    if (reset) ps2_clk_oe <= 1'b0;
    else       ps2_clk_oe <= full & ~do_pop & (state == IDLE) & ~fall;
  end
`else
  assign ps2_clk_oe = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_rx.sv
// Scoreboard bench for ps2_host_rx: good, bad-parity, bad-stop, timeout,
// overflow, glitch and mid-frame reset scenarios.
module tb_ps2_host_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int FIFO_BITS      = 2;
  localparam int HALF           = 20;
  localparam int DEPTH          = 1 << FIFO_BITS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_data_in = 1'b1;
  logic       rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       ps2_clk_oe;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int exp_par = 0, exp_frm = 0, exp_ovf = 0;
  int n_par = 0, n_frm = 0, n_ovf = 0;
  bit wide = 1'b0, overlap = 1'b0;
  logic prev_p = 1'b0, prev_f = 1'b0, prev_o = 1'b0;

  ps2_host_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FIFO_BITS      (FIFO_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_rd       (rx_rd),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .ps2_clk_oe  (ps2_clk_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err) n_par++;
    if (frame_err)  n_frm++;
    if (overflow)   n_ovf++;
    if ((parity_err && prev_p) || (frame_err && prev_f) || (overflow && prev_o)) wide = 1'b1;
    if (int'(parity_err) + int'(frame_err) + int'(overflow) > 1) overlap = 1'b1;
    prev_p = parity_err;
    prev_f = frame_err;
    prev_o = overflow;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data_in = b;
    idle(HALF);
    ps2_clk_in = 1'b0;
    idle(HALF);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(stop);
    ps2_data_in = 1'b1;
    if (!stop)                    exp_frm++;
    else if (bad_par)             exp_par++;
    else if (exp_q.size() == DEPTH) exp_ovf++;
    else                          exp_q.push_back(b);
    idle(3 * HALF);
  endtask

  task automatic check_errs(input string tag);
    check_eq({tag, " parity_err count"}, n_par, exp_par);
    check_eq({tag, " frame_err count"},  n_frm, exp_frm);
    check_eq({tag, " overflow count"},   n_ovf, exp_ovf);
  endtask

  task automatic drain(input string tag);
    logic [7:0] exp;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      check_eq({tag, " rx_valid"}, rx_valid, 1);
      check_eq({tag, " rx_data"},  rx_data,  exp);
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
    end
    @(negedge clk);
    check_eq({tag, " empty after reads"}, rx_valid, 0);
  endtask

  initial begin
    idle(5);
    check_eq("reset rx_valid",   rx_valid,   0);
    check_eq("reset parity_err", parity_err, 0);
    check_eq("reset frame_err",  frame_err,  0);
    check_eq("reset overflow",   overflow,   0);
    check_eq("reset ps2_clk_oe", ps2_clk_oe, 0);
    reset = 1'b0;
    idle(20);

    send_frame(8'h1C, 1'b0, 1'b1);
    check_errs("good 1C");
    drain("good 1C");

    send_frame(8'hF0, 1'b1, 1'b1);
    check_errs("badpar F0");
    check_eq("badpar rx_valid", rx_valid, 0);
    send_frame(8'hF0, 1'b0, 1'b1);
    drain("good F0");

    send_frame(8'h5A, 1'b0, 1'b0);
    check_errs("badstop 5A");
    check_eq("badstop rx_valid", rx_valid, 0);

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    ps2_data_in = 1'b1;
    idle(TIMEOUT_CYCLES + 100);
    exp_frm++;
    check_errs("timeout");
    send_frame(8'h12, 1'b0, 1'b1);
    check_errs("after timeout");
    drain("good 12");

    for (int i = 1; i <= DEPTH; i++) send_frame(8'(i), 1'b0, 1'b1);
`ifdef PS2_RX_INHIBIT_EN
    check_eq("inhibit when full", ps2_clk_oe, 1);
`else
    check_eq("oe tied low when full", ps2_clk_oe, 0);
`endif
    send_frame(8'(DEPTH + 1), 1'b0, 1'b1);
    check_errs("overflow");
`ifdef PS2_RX_INHIBIT_EN
    check_eq("inhibit after overflow", ps2_clk_oe, 1);
`endif
    drain("fifo drain");
    check_eq("oe after drain", ps2_clk_oe, 0);

    @(negedge clk);
    ps2_data_in = 1'b0;
    idle(HALF);
    ps2_clk_in = 1'b0;
    idle(3);
    ps2_clk_in = 1'b1;
    idle(HALF);
    ps2_data_in = 1'b1;
    idle(2 * HALF);
    check_errs("glitch");
    check_eq("glitch rx_valid", rx_valid, 0);
    send_frame(8'h33, 1'b0, 1'b1);
    check_errs("after glitch");
    drain("good 33");

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    ps2_data_in = 1'b1;
    idle(3);
    check_eq("midreset rx_valid", rx_valid, 0);
    check_eq("midreset oe", ps2_clk_oe, 0);
    reset = 1'b0;
    idle(2 * HALF);
    send_frame(8'h29, 1'b0, 1'b1);
    check_errs("after reset");
    drain("good 29");

    check_eq("pulse width one cycle", wide, 0);
    check_eq("pulses exclusive", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
